// File: rtl/lsu_pkg.sv
// Shared encodings and request-decode helpers for the load/store unit.
// Memory funct3 codes follow the RISC-V base ISA (loads and stores share size bits [1:0]).
package lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LD  = 3'b011;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_LWU = 3'b110;

    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;
    localparam logic [2:0] LSU_SD  = 3'b011;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
    } op_t;

    function automatic logic op_invalid(input op_t op, input logic rv64);
        if (op.store)
            return op.funct3[2] || (!rv64 && op.funct3 == LSU_SD);
        return (op.funct3 == 3'b111) ||
               (!rv64 && (op.funct3 == LSU_LD || op.funct3 == LSU_LWU));
    endfunction

    function automatic logic op_misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            SZ_H:    return lo[0] != 1'b0;
            SZ_W:    return lo[1:0] != 2'b00;
            SZ_D:    return lo != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-lane extract: shifts the addressed lane down, then sign/zero-extends.
// Zero latency; no handshake.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] lane;

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            LSU_LB:  data = XLEN'($signed(lane[7:0]));
            LSU_LH:  data = XLEN'($signed(lane[15:0]));
            LSU_LW:  data = XLEN'($signed(lane[31:0]));
            LSU_LBU: data = XLEN'(lane[7:0]);
            LSU_LHU: data = XLEN'(lane[15:0]);
            LSU_LWU: data = XLEN'(lane[31:0]);
            LSU_LD:  data = lane;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time over a ready/valid bus, one resp_valid pulse each.
// Bus path: accept -> mem_valid next cycle, resp 3 cycles after accept at zero wait; traps respond in 1.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_data,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);

    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    op_t              op_q;
    logic [OFF_W-1:0] off_q;

    op_t              op_in;
    logic [OFF_W-1:0] off_in;
    logic             trap_in;
    logic [BE_W-1:0]  be_base;
    logic [BE_W-1:0]  be_in;
    logic [XLEN-1:0]  wdata_in;
    logic [XLEN-1:0]  ext_data;

    assign op_in    = '{store: req_store, funct3: req_funct3};
    assign off_in   = req_addr[OFF_W-1:0];
    assign trap_in  = op_invalid(op_in, 1'(XLEN == 64)) ||
                      op_misaligned(req_funct3[1:0], req_addr[2:0]);
    assign be_in    = be_base << off_in;
    assign wdata_in = req_wdata << {off_in, 3'b000};

    always_comb begin
        be_base = '0;
        case (req_funct3[1:0])
            SZ_B:    be_base = BE_W'(1);
            SZ_H:    be_base = BE_W'(3);
            SZ_W:    be_base = BE_W'(15);
            default: be_base = '1;
        endcase
    end

    lsu_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extend (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (op_q.funct3),
        .data   (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            off_q      <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_q      <= op_in;
                        off_q     <= off_in;
                        if (trap_in) begin
                            // Traps never touch the bus.
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state     <= ST_REQ;
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_be    <= be_in;
                            mem_addr  <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= wdata_in;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state     <= ST_WAIT;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_err;
                        resp_data  <= (mem_err || op_q.store) ? '0 : ext_data;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: an XLEN=32 instance (a_*) and an XLEN=64 instance (b_*).
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_req_valid, a_req_ready, a_req_store;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_err;
    logic [31:0] a_resp_data;
    logic        a_mem_valid, a_mem_ready, a_mem_we;
    logic [3:0]  a_mem_be;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic        a_mem_rvalid, a_mem_err;
    logic [31:0] a_mem_rdata;

    logic        b_req_valid, b_req_ready, b_req_store;
    logic [2:0]  b_req_funct3;
    logic [63:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_err;
    logic [63:0] b_resp_data;
    logic        b_mem_valid, b_mem_ready, b_mem_we;
    logic [7:0]  b_mem_be;
    logic [63:0] b_mem_addr, b_mem_wdata;
    logic        b_mem_rvalid, b_mem_err;
    logic [63:0] b_mem_rdata;

    lsu #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(a_req_store),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_err(a_resp_err), .resp_data(a_resp_data),
        .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_we(a_mem_we),
        .mem_be(a_mem_be), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata), .mem_err(a_mem_err)
    );

    lsu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_store(b_req_store),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_err(b_resp_err), .resp_data(b_resp_data),
        .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_we(b_mem_we),
        .mem_be(b_mem_be), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .mem_err(b_mem_err)
    );

    // Observations captured by run(): bus fields one cycle after accept, then the response.
    logic        c1_valid, c1_we;
    logic [7:0]  c1_be;
    logic [63:0] c1_addr, c1_wdata;
    int          r_lat;
    logic        r_err;
    logic [63:0] r_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request against a zero-wait bus; r_lat = cycles from accept to resp_valid (0 = timeout).
    task automatic run(input bit w64, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata, input bit err);
        bit pend;
        if (w64) begin
            b_req_valid = 1'b1; b_req_store = st; b_req_funct3 = f3;
            b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = 1'b1; a_req_store = st; a_req_funct3 = f3;
            a_req_addr = addr[31:0]; a_req_wdata = wdata[31:0];
        end
        a_mem_rdata = rdata[31:0]; b_mem_rdata = rdata;
        a_mem_err = err; b_mem_err = err;
        a_mem_ready = 1'b1; b_mem_ready = 1'b1;
        tick;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        pend = 1'b0;
        r_lat = 0; r_err = 1'bx; r_data = 'x;
        for (int c = 1; c <= 20; c++) begin
            a_mem_rvalid = pend && !w64;
            b_mem_rvalid = pend && w64;
            if (c == 1) begin
                c1_valid = w64 ? b_mem_valid : a_mem_valid;
                c1_we    = w64 ? b_mem_we : a_mem_we;
                c1_be    = w64 ? b_mem_be : {4'b0, a_mem_be};
                c1_addr  = w64 ? b_mem_addr : {32'b0, a_mem_addr};
                c1_wdata = w64 ? b_mem_wdata : {32'b0, a_mem_wdata};
            end
            if (w64 ? b_resp_valid : a_resp_valid) begin
                r_lat  = c;
                r_err  = w64 ? b_resp_err : a_resp_err;
                r_data = w64 ? b_resp_data : {32'b0, a_resp_data};
                break;
            end
            pend = w64 ? b_mem_valid : a_mem_valid;
            tick;
        end
        a_mem_rvalid = 1'b0; b_mem_rvalid = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        a_req_valid = 0; a_req_store = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
        a_mem_ready = 1; a_mem_rvalid = 0; a_mem_rdata = 0; a_mem_err = 0;
        b_req_valid = 0; b_req_store = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
        b_mem_ready = 1; b_mem_rvalid = 0; b_mem_rdata = 0; b_mem_err = 0;

        repeat (2) tick;
        chk("rst_req_ready32", a_req_ready, 0);
        chk("rst_mem_valid32", a_mem_valid, 0);
        chk("rst_resp_valid32", a_resp_valid, 0);
        chk("rst_req_ready64", b_req_ready, 0);
        rst = 1'b0;
        tick;
        chk("post_rst_ready32", a_req_ready, 1);
        chk("post_rst_ready64", b_req_ready, 1);

        run(0, 1, LSU_SW, 64'h104, 64'hDEADBEEF, 64'h0, 0);
        chk("sw_mem_valid", c1_valid, 1);
        chk("sw_mem_addr", c1_addr, 64'h104);
        chk("sw_mem_be", c1_be, 8'h0F);
        chk("sw_mem_wdata", c1_wdata, 64'hDEADBEEF);
        chk("sw_mem_we", c1_we, 1);
        chk("sw_lat", r_lat, 3);
        chk("sw_err", r_err, 0);
        chk("sw_data", r_data, 0);
        chk("sw_ready_after", a_req_ready, 1);

        run(0, 0, LSU_LB, 64'h103, 64'h0, 64'h80FF1234, 0);
        chk("lb_mem_addr", c1_addr, 64'h100);
        chk("lb_mem_be", c1_be, 8'h08);
        chk("lb_mem_we", c1_we, 0);
        chk("lb_lat", r_lat, 3);
        chk("lb_data", r_data, 64'hFFFFFF80);

        run(0, 0, LSU_LBU, 64'h103, 64'h0, 64'h80FF1234, 0);
        chk("lbu_data", r_data, 64'h00000080);
        chk("lbu_err", r_err, 0);

        run(0, 0, LSU_LH, 64'h101, 64'h0, 64'h0, 0);
        chk("lh_mis_mem_valid", c1_valid, 0);
        chk("lh_mis_lat", r_lat, 1);
        chk("lh_mis_err", r_err, 1);
        chk("lh_mis_data", r_data, 0);

        run(0, 0, 3'b111, 64'h100, 64'h0, 64'h0, 0);
        chk("ld111_mem_valid", c1_valid, 0);
        chk("ld111_lat", r_lat, 1);
        chk("ld111_err", r_err, 1);

        run(0, 0, LSU_LD, 64'h100, 64'h0, 64'h0, 0);
        chk("ld32_inv_lat", r_lat, 1);
        chk("ld32_inv_err", r_err, 1);

        run(0, 0, LSU_LW, 64'h200, 64'h0, 64'h12345678, 1);
        chk("lw_buserr_lat", r_lat, 3);
        chk("lw_buserr_err", r_err, 1);
        chk("lw_buserr_data", r_data, 0);
        a_mem_err = 0; b_mem_err = 0;

        // SH with mem_ready low for cycles 1-3, ready at 4, rvalid at 6 -> resp at 7.
        a_mem_ready = 0;
        a_req_valid = 1; a_req_store = 1; a_req_funct3 = LSU_SH;
        a_req_addr = 32'h102; a_req_wdata = 32'h00001234;
        tick;
        a_req_valid = 0;
        for (int c = 1; c <= 7; c++) begin
            a_mem_ready  = (c == 4);
            a_mem_rvalid = (c == 6);
            chk($sformatf("sh_mem_valid_c%0d", c), a_mem_valid, (c <= 4));
            chk($sformatf("sh_resp_valid_c%0d", c), a_resp_valid, (c == 7));
            chk($sformatf("sh_req_ready_c%0d", c), a_req_ready, 0);
            if (c <= 4) begin
                chk($sformatf("sh_be_c%0d", c), a_mem_be, 4'b1100);
                chk($sformatf("sh_wdata_c%0d", c), a_mem_wdata, 32'h12340000);
                chk($sformatf("sh_addr_c%0d", c), a_mem_addr, 32'h100);
                chk($sformatf("sh_we_c%0d", c), a_mem_we, 1);
            end
            if (c == 7) begin
                chk("sh_err", a_resp_err, 0);
                chk("sh_data", a_resp_data, 0);
            end else begin
                tick;
            end
        end
        a_mem_rvalid = 0; a_mem_ready = 1;
        tick;
        chk("sh_resp_drop", a_resp_valid, 0);
        chk("sh_ready_after", a_req_ready, 1);

        // Reset during a trap response: the pulse must vanish immediately.
        a_req_valid = 1; a_req_store = 0; a_req_funct3 = LSU_LW; a_req_addr = 32'h202;
        tick;
        a_req_valid = 0;
        chk("trap_resp_before_rst", a_resp_valid, 1);
        rst = 1; #1;
        chk("rst_resp_valid_async", a_resp_valid, 0);
        chk("rst_resp_err_async", a_resp_err, 0);
        tick;
        rst = 0;
        tick;

        // Reset during WAIT, then a late bus response is ignored.
        a_req_valid = 1; a_req_store = 0; a_req_funct3 = LSU_LW; a_req_addr = 32'h200;
        tick;
        a_req_valid = 0;
        chk("wait_rst_mem_valid_c1", a_mem_valid, 1);
        tick;
        chk("wait_rst_mem_valid_c2", a_mem_valid, 0);
        chk("wait_rst_ready_c2", a_req_ready, 0);
        rst = 1; #1;
        chk("wait_rst_ready_async", a_req_ready, 0);
        chk("wait_rst_mem_valid_async", a_mem_valid, 0);
        chk("wait_rst_mem_be_async", a_mem_be, 0);
        chk("wait_rst_resp_valid_async", a_resp_valid, 0);
        tick;
        rst = 0;
        tick;
        chk("wait_rst_ready_release", a_req_ready, 1);
        a_mem_rvalid = 1; a_mem_rdata = 32'hCAFEF00D;
        tick;
        a_mem_rvalid = 0;
        chk("late_rvalid_resp_c1", a_resp_valid, 0);
        tick;
        chk("late_rvalid_resp_c2", a_resp_valid, 0);
        chk("late_rvalid_ready", a_req_ready, 1);

        run(1, 0, LSU_LWU, 64'h1004, 64'h0, 64'h80000001_00000000, 0);
        chk("lwu64_addr", c1_addr, 64'h1000);
        chk("lwu64_be", c1_be, 8'hF0);
        chk("lwu64_lat", r_lat, 3);
        chk("lwu64_data", r_data, 64'h00000000_80000001);

        run(1, 0, LSU_LW, 64'h1004, 64'h0, 64'h80000001_00000000, 0);
        chk("lw64_data", r_data, 64'hFFFFFFFF_80000001);

        run(1, 1, LSU_SD, 64'h1004, 64'h11223344_55667788, 64'h0, 0);
        chk("sd64_mis_mem_valid", c1_valid, 0);
        chk("sd64_mis_lat", r_lat, 1);
        chk("sd64_mis_err", r_err, 1);

        run(1, 1, LSU_SD, 64'h1008, 64'h11223344_55667788, 64'h0, 0);
        chk("sd64_be", c1_be, 8'hFF);
        chk("sd64_wdata", c1_wdata, 64'h11223344_55667788);
        chk("sd64_lat", r_lat, 3);
        chk("sd64_err", r_err, 0);

        run(1, 1, LSU_SH, 64'h1006, 64'h0000_0000_0000_ABCD, 64'h0, 0);
        chk("sh64_be", c1_be, 8'hC0);
        chk("sh64_wdata", c1_wdata, 64'hABCD0000_00000000);

        run(1, 0, LSU_LD, 64'h1000, 64'h0, 64'h01234567_89ABCDEF, 0);
        chk("ld64_data", r_data, 64'h01234567_89ABCDEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
